// File: rtl/cdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : cdiv_seq
// Description : Sequential complex divider Z = X / Y (Y in Q2.11).
//               Z = X*conj(Y) / |Y|^2 using a restoring divider with the
//               real and imaginary lanes iterated in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module cdiv_seq #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X_re,
  input  logic [WIDTH-1:0] X_im,
  input  logic [12:0]      Y_re,
  input  logic [12:0]      Y_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z_re,
  output logic [WIDTH-1:0] Z_im,
  output logic             ovf,
  output logic             dz
);

  // Numerator width, dividend/divisor datapath width, counter width
  localparam int NW = WIDTH + 14;
  localparam int AW = WIDTH + 26;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] x_re, x_im;
  logic signed [12:0]      y_re, y_im;
  logic [AW-1:0]           a_re, a_im;
  logic [AW-1:0]           dsh;
  logic [WIDTH-2:0]        q_re, q_im;
  logic                    neg_re, neg_im;
  logic                    sat_re, sat_im;
  logic                    dz_r;
  logic [CW-1:0]           cnt;

  // Products for the MUL cycle, taken from the captured operands
  logic signed [NW-1:0] n_re, n_im;
  logic signed [25:0]   yr2, yi2;
  logic [25:0]          d;
  logic [NW-1:0]        abs_re, abs_im;
  logic [AW-1:0]        a0_re, a0_im, d_lim, dsh0;

  assign n_re   = NW'(x_re) * NW'(y_re) + NW'(x_im) * NW'(y_im);
  assign n_im   = NW'(x_im) * NW'(y_re) - NW'(x_re) * NW'(y_im);
  assign yr2    = 26'(y_re) * 26'(y_re);
  assign yi2    = 26'(y_im) * 26'(y_im);
  assign d      = yr2 + yi2;
  assign abs_re = n_re[NW-1] ? -n_re : n_re;
  assign abs_im = n_im[NW-1] ? -n_im : n_im;
  // Dividend is |N| rescaled by 2^11 so the quotient keeps X's scale
  assign a0_re  = {1'b0, abs_re, 11'b0};
  assign a0_im  = {1'b0, abs_im, 11'b0};
  // Quotient magnitude must fit in WIDTH-1 bits: A < D * 2^(WIDTH-1)
  assign d_lim  = {1'b0, d, {(WIDTH-1){1'b0}}};
  // Divisor aligned to the quotient MSB; shifted right once per iteration
  assign dsh0   = {2'b0, d, {(WIDTH-2){1'b0}}};

  // One restoring-division step per lane
  logic             ge_re, ge_im;
  logic [AW-1:0]    a_re_nx, a_im_nx;
  logic [WIDTH-2:0] q_re_nx, q_im_nx;

  assign ge_re   = (a_re >= dsh);
  assign ge_im   = (a_im >= dsh);
  assign a_re_nx = ge_re ? (a_re - dsh) : a_re;
  assign a_im_nx = ge_im ? (a_im - dsh) : a_im;
  assign q_re_nx = {q_re[WIDTH-3:0], ge_re};
  assign q_im_nx = {q_im[WIDTH-3:0], ge_im};

  // Apply saturation then the lane sign; saturation is symmetric
  function automatic logic [WIDTH-1:0] fmt_lane(input logic neg, input logic sat,
                                                input logic [WIDTH-2:0] q);
    logic [WIDTH-1:0] m;
    m = sat ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b0, q};
    return neg ? -m : m;
  endfunction

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Z_re      <= '0;
      Z_im      <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
      a_re      <= '0;
      a_im      <= '0;
      dsh       <= '0;
      q_re      <= '0;
      q_im      <= '0;
      neg_re    <= 1'b0;
      neg_im    <= 1'b0;
      sat_re    <= 1'b0;
      sat_im    <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_re     <= X_re;
            x_im     <= X_im;
            y_re     <= Y_re;
            y_im     <= Y_im;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          a_re   <= a0_re;
          a_im   <= a0_im;
          dsh    <= dsh0;
          neg_re <= n_re[NW-1];
          neg_im <= n_im[NW-1];
          sat_re <= (a0_re >= d_lim);
          sat_im <= (a0_im >= d_lim);
          dz_r   <= (d == 26'd0);
          q_re   <= '0;
          q_im   <= '0;
          cnt    <= CW'(WIDTH - 2);
          state  <= DIV;
        end
        DIV: begin
          a_re <= a_re_nx;
          a_im <= a_im_nx;
          q_re <= q_re_nx;
          q_im <= q_im_nx;
          dsh  <= dsh >> 1;
          if (cnt == '0) begin
            // Final step: form the signed, saturated result for DONE
            Z_re  <= dz_r ? '0 : fmt_lane(neg_re, sat_re, q_re_nx);
            Z_im  <= dz_r ? '0 : fmt_lane(neg_im, sat_im, q_im_nx);
            ovf   <= ~dz_r & (sat_re | sat_im);
            dz    <= dz_r;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdiv_seq
// Description : Self-checking bench for cdiv_seq (WIDTH=13) with directed
//               cases and random operands against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdiv_seq;

  localparam int WIDTH = 13;
  localparam int MAXV  = (1 << (WIDTH - 1)) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X_re, X_im;
  logic [12:0]      Y_re, Y_im;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z_re, Z_im;
  logic             ovf;
  logic             dz;

  int n_assert = 0;
  int n_fail   = 0;

  cdiv_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X_re     (X_re),
    .X_im     (X_im),
    .Y_re     (Y_re),
    .Y_im     (Y_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z_re     (Z_re),
    .Z_im     (Z_im),
    .ovf      (ovf),
    .dz       (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact rational quotient X*conj(Y)*2048/|Y|^2, truncated
  task automatic lane_model(input longint n, input longint d,
                            output int z, output logic o);
    longint mag;
    mag = ((n < 0) ? -n : n) * 2048 / d;
    o   = 1'b0;
    if (mag > MAXV) begin
      mag = MAXV;
      o   = 1'b1;
    end
    z = int'((n < 0) ? -mag : mag);
  endtask

  task automatic model(input int xr, input int xi, input int yr, input int yi,
                       output int zr, output int zi, output logic ov, output logic dzo);
    longint nre, nim, d;
    logic o1, o2;
    nre = longint'(xr) * yr + longint'(xi) * yi;
    nim = longint'(xi) * yr - longint'(xr) * yi;
    d   = longint'(yr) * yr + longint'(yi) * yi;
    if (d == 0) begin
      zr = 0; zi = 0; ov = 1'b0; dzo = 1'b1;
    end else begin
      lane_model(nre, d, zr, o1);
      lane_model(nim, d, zi, o2);
      ov  = o1 | o2;
      dzo = 1'b0;
    end
  endtask

  function automatic logic signed [31:0] sz(input logic [WIDTH-1:0] v);
    return 32'($signed(v));
  endfunction

  // One full transaction: accept, latency, result, optional hold, handshake
  task automatic run_op(input int xr, input int xi, input int yr, input int yi,
                        input int hold, input bit noise);
    int zr, zi, lat, n;
    logic ov, dzv;
    model(xr, xi, yr, yi, zr, zi, ov, dzv);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    X_re = WIDTH'(xr); X_im = WIDTH'(xi);
    Y_re = 13'(yr);    Y_im = 13'(yi);
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      // Busy: new operands and a stray out_ready must be ignored
      X_re = WIDTH'(777); X_im = WIDTH'(-3); Y_re = 13'(5); Y_im = 13'(0);
      out_ready = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) out_ready = 1'b0;
    end
    out_ready = 1'b0;
    chk("latency", lat, WIDTH + 1);
    chk("z_re", sz(Z_re), zr);
    chk("z_im", sz(Z_im), zi);
    chk("ovf", ovf, ov);
    chk("dz", dz, dzv);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_z_re", sz(Z_re), zr);
      chk("hold_z_im", sz(Z_im), zi);
      chk("hold_flags", {ovf, dz}, {ov, dzv});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    bit seen;
    int xr, xi, yr, yi;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    X_re = '0; X_im = '0; Y_re = '0; Y_im = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", {sz(Z_re), sz(Z_im)} == 64'd0, 1);
    chk("rst_flags", {ovf, dz}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(1024, 0, 2048, 0, 0, 0);
    run_op(0, 1024, 0, 2048, 0, 0);
    run_op(1000, -500, 1024, 0, 1, 0);
    run_op(1000, 0, 1536, 0, 0, 0);
    run_op(-1000, 0, 1536, 0, 0, 0);
    run_op(2000, -2000, 256, 0, 0, 0);
    run_op(-1234, 567, 0, 0, 0, 0);
    run_op(0, 0, 300, -700, 0, 0);
    run_op(-4096, -4096, -4096, -4096, 0, 0);
    // Long stall in DONE with stray input traffic
    run_op(1500, -800, 2000, 900, 10, 1);

    // Random operands, some with small divisors to provoke saturation
    for (int k = 0; k < 30; k++) begin
      xr = int'($urandom_range(0, 8191)) - 4096;
      xi = int'($urandom_range(0, 8191)) - 4096;
      if ($urandom_range(0, 3) == 0) begin
        yr = int'($urandom_range(0, 600)) - 300;
        yi = int'($urandom_range(0, 600)) - 300;
      end else begin
        yr = int'($urandom_range(0, 8191)) - 4096;
        yi = int'($urandom_range(0, 8191)) - 4096;
      end
      run_op(xr, xi, yr, yi, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset during the fifth division iteration
    run_op(1024, 0, 2048, 0, 0, 0);
    @(negedge clk);
    X_re = WIDTH'(1000); X_im = '0; Y_re = 13'(1536); Y_im = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_z", {sz(Z_re), sz(Z_im)} == 64'd0, 1);
    chk("arst_flags", {ovf, dz}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_result", seen, 0);
    run_op(1024, 0, 2048, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
